boss_attack_ctrl: RTL
=====================

// Module: boss_attack_ctrl
// PURPOSE
//  Attack-pattern controller for the final-stage boss. Drives the boss mover's command inputs:
//  spawn, Boss_exists, flydown, rise, hold, back_and_forth. Consumes its status returns:
//  hit_top, hit_bottom, beat_Boss. Sequences spawn -> sweep -> telegraph -> dive -> rise,
//  looping until defeat. Also emits a boss-laser fire strobe during sweeps.
// PARAMETERS
//  SPAWN_FRAMES   2     frames spawn is held; the mover needs 2 frames to load its start position
//  SWEEP_EASY     240   sweep duration in frames, easy difficulty
//  SWEEP_MED      180   sweep duration in frames, difficulty[1]
//  SWEEP_HARD     120   sweep duration in frames, difficulty[2]
//  FIRE_EASY      60    frames between fire strobes, easy
//  FIRE_MED       40    frames between fire strobes, medium
//  FIRE_HARD      24    frames between fire strobes, hard
//  HOLD_FRAMES    30    telegraph pause before each dive
//  DIVE_TIMEOUT   120   guard: leave DIVE if hit_bottom never arrives
// PORTS
//  frame_clk       in   1   frame clock; sole clock
//  Reset           in   1   synchronous, active-high reset
//  start           in   1   level; high while the boss stage is active
//  difficulty      in   3   [1] medium, [2] hard (medium wins if both), else easy; sampled every frame
//  hit_top         in   1   mover status: boss reached top during rise
//  hit_bottom      in   1   mover status: boss reached bottom during flydown
//  beat_Boss       in   1   mover status: health exhausted
//  spawn           out  1   mover command
//  Boss_exists     out  1   mover enable / collision enable
//  flydown         out  1   mover command
//  rise            out  1   mover command
//  hold            out  1   mover command
//  back_and_forth  out  1   mover command
//  boss_fire       out  1   1-frame strobe: launch a boss laser
//  boss_defeated   out  1   level; high in DEFEATED
//  dive_count      out  4   completed dive/rise cycles, saturating at 15
//  state_dbg       out  3   encoded current state
// BEHAVIOUR
//  - All registers update on the posedge of frame_clk. Reset=1 -> IDLE, all timers and dive_count 0.
//  - Outputs are a Moore decode of the state register. Every output is 0 in IDLE, including
//    state_dbg = 0.
//  - Input sampled at edge k takes effect after edge k. The mover sees the new command at edge k+1.
//  - States and commands:
//    IDLE(0):      no command asserted; Boss_exists = 0.
//    SPAWN(1):     spawn = 1; Boss_exists = 0.
//    SWEEP(2):     Boss_exists = 1; back_and_forth = 1.
//    TELEGRAPH(3): Boss_exists = 1; hold = 1.
//    DIVE(4):      Boss_exists = 1; flydown = 1.
//    RISE(5):      Boss_exists = 1; rise = 1.
//    DEFEATED(6):  no command asserted; Boss_exists = 0; boss_defeated = 1.
//  - In SWEEP, TELEGRAPH, DIVE and RISE, exactly one of flydown, rise, hold, back_and_forth is
//    high (one-hot).
//  - Transitions:
//    IDLE -> SPAWN when start = 1.
//    SPAWN -> SWEEP after SPAWN_FRAMES frames.
//    SWEEP -> TELEGRAPH when the sweep timer expires; its limit is selected by difficulty at SWEEP entry.
//    TELEGRAPH -> DIVE after HOLD_FRAMES frames.
//    DIVE -> RISE on hit_bottom = 1, or after DIVE_TIMEOUT frames.
//    RISE -> SWEEP on hit_top = 1; dive_count increments (saturating) on this transition.
//    DEFEATED -> IDLE when start = 0.
//  - hit_top is ignored outside RISE and hit_bottom is ignored outside DIVE. The mover holds hit_top
//    high after a rise; that must not retrigger anything.
//  - Priority, highest first:
//    1. Reset.
//    2. beat_Boss = 1 in SWEEP, TELEGRAPH, DIVE or RISE forces DEFEATED.
//    3. start = 0 in any non-IDLE, non-DEFEATED state forces IDLE.
//    4. Normal transitions.
//  - Timer: 10-bit frame counter. Cleared on every state change. A state with duration N lasts
//    exactly N frames.
//  - Fire counter: 10-bit; cleared on SWEEP entry. boss_fire pulses on the frame the counter equals
//    FIRE_x-1, then the counter wraps to 0. boss_fire never pulses outside SWEEP, including on the
//    exit frame.
//  - beat_Boss is sampled only in the active states, so a stale beat_Boss in IDLE or SPAWN is ignored.
// STRUCTURE
//  - boss_pkg holds: the state enum boss_state_t (3-bit); a difficulty-decode function returning
//    sweep and fire limits; the frame-count constants.
//  - One sub-module, frame_timer: clear input, count output, done = (count == limit-1). It is
//    instantiated twice: the state timer and the fire counter.
//  - The FSM and output decode live in this file.
// TESTING
//  1. Reset, start=1, difficulty=0.
//     -> spawn high for exactly 2 frames, then back_and_forth for 240 frames, then hold for 30,
//        then flydown.
//     -> boss_fire pulses at sweep frames 59, 119, 179 and 239.
//  2. In DIVE, assert hit_bottom 15 frames in.
//     -> rise on the next frame.
//     -> Then hit_top -> back_and_forth, dive_count = 1. Repeat 16 cycles -> dive_count stays 15.
//  3. difficulty=3'b100.
//     -> Sweep lasts 120 frames; fire period is 24.
//     Switch difficulty mid-sweep.
//     -> The sweep limit is unchanged until the next SWEEP entry.
//  4. Hold hit_bottom low in DIVE.
//     -> RISE after exactly 120 frames.
//     Hold hit_top high entering TELEGRAPH.
//     -> No early transition.
//  5. beat_Boss=1 during DIVE.
//     -> Next frame: DEFEATED, all commands 0, Boss_exists=0, boss_defeated=1.
//     Drop start.
//     -> IDLE.
//  6. Reset pulse mid-RISE and start=0 mid-SWEEP.
//     -> IDLE next frame, timers cleared; Reset also clears dive_count.

Source files
------------

// File: rtl/boss_pkg.sv
// Shared types and frame-count constants for the boss attack controller.
package boss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SPAWN     = 3'd1,
        ST_SWEEP     = 3'd2,
        ST_TELEGRAPH = 3'd3,
        ST_DIVE      = 3'd4,
        ST_RISE      = 3'd5,
        ST_DEFEATED  = 3'd6
    } boss_state_t;

    localparam int TW = 10;

    localparam logic [TW-1:0] SPAWN_FRAMES = 10'd2;
    localparam logic [TW-1:0] SWEEP_EASY   = 10'd240;
    localparam logic [TW-1:0] SWEEP_MED    = 10'd180;
    localparam logic [TW-1:0] SWEEP_HARD   = 10'd120;
    localparam logic [TW-1:0] FIRE_EASY    = 10'd60;
    localparam logic [TW-1:0] FIRE_MED     = 10'd40;
    localparam logic [TW-1:0] FIRE_HARD    = 10'd24;
    localparam logic [TW-1:0] HOLD_FRAMES  = 10'd30;
    localparam logic [TW-1:0] DIVE_TIMEOUT = 10'd120;

    typedef struct packed {
        logic [TW-1:0] sweep;
        logic [TW-1:0] fire;
    } diff_lim_t;

    // Medium wins over hard when both bits are set; neither means easy.
    function automatic diff_lim_t diff_decode(input logic med, input logic hard);
        diff_lim_t r;
        if (med) begin
            r.sweep = SWEEP_MED;
            r.fire  = FIRE_MED;
        end else if (hard) begin
            r.sweep = SWEEP_HARD;
            r.fire  = FIRE_HARD;
        end else begin
            r.sweep = SWEEP_EASY;
            r.fire  = FIRE_EASY;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter with synchronous clear; done flags the last frame of a limit-long window.
module frame_timer #(
    parameter int W = 10
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         done
);

    // Count frames; clear takes priority over incrementing.
    always_ff @(posedge frame_clk) begin
        if (Reset || clear) count <= '0;
        else                count <= count + W'(1);
    end

    assign done = (count == limit - W'(1));

endmodule

// File: rtl/boss_attack_ctrl.sv
// Final-stage boss attack sequencer: spawn -> sweep -> telegraph -> dive -> rise, until defeated.
module boss_attack_ctrl
    import boss_pkg::*;
(
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [2:0] difficulty,
    input  logic       hit_top,
    input  logic       hit_bottom,
    input  logic       beat_Boss,
    output logic       spawn,
    output logic       Boss_exists,
    output logic       flydown,
    output logic       rise,
    output logic       hold,
    output logic       back_and_forth,
    output logic       boss_fire,
    output logic       boss_defeated,
    output logic [3:0] dive_count,
    output logic [2:0] state_dbg
);

    boss_state_t   state, state_nxt;
    diff_lim_t     lim_now;
    logic [TW-1:0] sweep_lim, st_limit, st_count, fire_count;
    logic          st_done, fire_done, active, sweep_entry;
    logic          unused_ok;

    assign lim_now     = diff_decode(difficulty[1], difficulty[2]);
    assign active      = (state == ST_SWEEP) || (state == ST_TELEGRAPH) ||
                         (state == ST_DIVE)  || (state == ST_RISE);
    assign sweep_entry = (state != ST_SWEEP) && (state_nxt == ST_SWEEP);
    assign unused_ok   = ^{st_count, fire_count, difficulty[0]};

    // Per-state duration; states without a duration leave done effectively unreachable.
    always_comb begin
        st_limit = '0;
        case (state)
            ST_SPAWN:     st_limit = SPAWN_FRAMES;
            ST_SWEEP:     st_limit = sweep_lim;
            ST_TELEGRAPH: st_limit = HOLD_FRAMES;
            ST_DIVE:      st_limit = DIVE_TIMEOUT;
            default:      st_limit = '0;
        endcase
    end

    // State timer restarts on every state change so each state starts at frame 0.
    frame_timer #(.W(TW)) u_state_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     (state_nxt != state),
        .limit     (st_limit),
        .count     (st_count),
        .done      (st_done)
    );

    // Fire counter only runs in SWEEP and wraps after each strobe; fire period follows live difficulty.
    frame_timer #(.W(TW)) u_fire_timer (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clear     ((state != ST_SWEEP) || fire_done),
        .limit     (lim_now.fire),
        .count     (fire_count),
        .done      (fire_done)
    );

    // Next-state: defeat beats stage-abort, which beats the normal sequence.
    always_comb begin
        state_nxt = state;
        if (active && beat_Boss) begin
            state_nxt = ST_DEFEATED;
        end else if ((state != ST_IDLE) && (state != ST_DEFEATED) && !start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start)                  state_nxt = ST_SPAWN;
                ST_SPAWN:     if (st_done)                state_nxt = ST_SWEEP;
                ST_SWEEP:     if (st_done)                state_nxt = ST_TELEGRAPH;
                ST_TELEGRAPH: if (st_done)                state_nxt = ST_DIVE;
                ST_DIVE:      if (hit_bottom || st_done)  state_nxt = ST_RISE;
                ST_RISE:      if (hit_top)                state_nxt = ST_SWEEP;
                ST_DEFEATED:  if (!start)                 state_nxt = ST_IDLE;
                default:                                  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge frame_clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Sweep length is locked in at SWEEP entry so mid-sweep difficulty changes wait a cycle.
    always_ff @(posedge frame_clk) begin
        if (Reset)            sweep_lim <= SWEEP_EASY;
        else if (sweep_entry) sweep_lim <= lim_now.sweep;
    end

    // Completed dive/rise cycles, saturating.
    always_ff @(posedge frame_clk) begin
        if (Reset)
            dive_count <= '0;
        else if ((state == ST_RISE) && (state_nxt == ST_SWEEP) && (dive_count != 4'hF))
            dive_count <= dive_count + 4'd1;
    end

    // Moore command decode; fire strobe is gated by SWEEP so it never leaks past the exit.
    always_comb begin
        spawn          = 1'b0;
        Boss_exists    = 1'b0;
        flydown        = 1'b0;
        rise           = 1'b0;
        hold           = 1'b0;
        back_and_forth = 1'b0;
        boss_defeated  = 1'b0;
        case (state)
            ST_SPAWN:     spawn = 1'b1;
            ST_SWEEP:     begin Boss_exists = 1'b1; back_and_forth = 1'b1; end
            ST_TELEGRAPH: begin Boss_exists = 1'b1; hold = 1'b1; end
            ST_DIVE:      begin Boss_exists = 1'b1; flydown = 1'b1; end
            ST_RISE:      begin Boss_exists = 1'b1; rise = 1'b1; end
            ST_DEFEATED:  boss_defeated = 1'b1;
            default:      ;
        endcase
    end

    assign boss_fire = (state == ST_SWEEP) && fire_done;
    assign state_dbg = state;

endmodule
